// File: rtl/vco_adc_pkg.sv
// Shared definitions for the VCO-based ADC back-end: FSM states, parameter
// defaults and the counter width helper.
package vco_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2
    } state_t;

    localparam int OSR_DEF        = 256;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int DATA_W_DEF     = 16;

    // Bits needed for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous single-bit input, followed by a
// history flop that flags rising edges of the synchronized signal.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic p,
    output logic p_sync,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= p;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign p_sync = s2;
    assign rise   = s2 & ~s3;

endmodule

// File: rtl/vco_edge_decoder.sv
// VCO phase edge counter: enables the VCO, counts rising edges of p over
// OSR-cycle windows and hands each count out over a valid/ready port.
module vco_edge_decoder
    import vco_adc_pkg::*;
#(
    parameter int OSR        = OSR_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              p,
    output logic              vco_enb,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic              busy
);

    localparam int WW = cnt_w(OSR);
    localparam int SW = cnt_w(SETTLE_CYC);
    localparam logic [WW-1:0]     W_LAST = WW'(OSR - 1);
    localparam logic [SW-1:0]     S_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [DATA_W-1:0] E_MAX  = '1;

    state_t            state, state_next;
    logic [WW-1:0]     w;
    logic [SW-1:0]     scnt;
    logic [DATA_W-1:0] e, e_final;
    logic              rise;
    logic              vco_enb_d, busy_d;
    logic              window_end, xfer, load;

    // Synchronized level is not needed here; only the edge strobe is counted.
    sync_edge_det u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .p      (p),
        .p_sync (),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (en) state_next = ST_SETTLE;
            ST_SETTLE: if (!en) state_next = ST_IDLE;
                       else if (scnt == S_LAST) state_next = ST_COUNT;
            ST_COUNT:  if (!en) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Decoded from the next state so the registered outputs line up with it.
    always_comb begin
        vco_enb_d = (state_next == ST_IDLE);
        busy_d    = (state_next != ST_IDLE);
    end

    assign e_final    = (rise && e != E_MAX) ? e + 1'b1 : e;
    assign window_end = (state == ST_COUNT) && en && (w == W_LAST);
    assign xfer       = sample_valid & sample_ready;
    assign load       = window_end && (!sample_valid || sample_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            w    <= '0;
            e    <= '0;
        end else begin
            scnt <= (state == ST_SETTLE) ? scnt + 1'b1 : '0;
            if (state == ST_COUNT) begin
                if (w == W_LAST) begin
                    w <= '0;
                    e <= '0;
                end else begin
                    w <= w + 1'b1;
                    e <= e_final;
                end
            end else begin
                w <= '0;
                e <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vco_enb      <= 1'b1;
            busy         <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            vco_enb <= vco_enb_d;
            busy    <= busy_d;
            if (load) begin
                sample_data  <= e_final;
                sample_valid <= 1'b1;
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (window_end && !load) overrun <= 1'b1;
            else if (clr_ovr)        overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vco_edge_decoder.sv
// Scoreboard bench for vco_edge_decoder with OSR=16, SETTLE_CYC=4.
module tb_vco_edge_decoder;

    localparam int OSR    = 16;
    localparam int SETTLE = 4;
    localparam int DW     = 16;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, p = 1'b0;
    logic          sample_ready = 1'b0, clr_ovr = 1'b0;
    logic          vco_enb, sample_valid, overrun, busy;
    logic [DW-1:0] sample_data;

    int            checks = 0, errors = 0, pops = 0, t = 0;
    logic          tog = 1'b0, p_lvl = 1'b0;
    logic [DW-1:0] exp_q[$];

    vco_edge_decoder #(.OSR(OSR), .SETTLE_CYC(SETTLE), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .p            (p),
        .vco_enb      (vco_enb),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Phase source: toggles every clock or holds a static level.
    initial forever begin
        @(posedge clk);
        #2;
        p = tog ? ~p : p_lvl;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            step();
            n++;
        end
        chk("pop_timeout", pops, target);
    endtask

    task automatic wait_valid(input int budget);
        while (!sample_valid && t < budget) step();
    endtask

    // Consumer side: every transfer pops one expected sample.
    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
            else begin
                chk("sample", sample_data, exp_q.pop_front());
                pops++;
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enb",   vco_enb, 1);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data",  sample_data, 0);
        chk("rst_ovr",   overrun, 0);
        chk("rst_busy",  busy, 0);
        rst_n = 1'b1;

        // Toggling input, ready held: every window counts 8
        sample_ready = 1'b1;
        tog = 1'b1;
        steps(4);
        repeat (3) exp_q.push_back(16'd8);
        base = pops;
        en = 1'b1;
        t = 0;
        step();
        chk("start_enb",  vco_enb, 0);
        chk("start_busy", busy, 1);
        wait_valid(100);
        chk("first_valid_t", t, 1 + SETTLE + OSR);
        wait_pops(base + 3, 80);
        en = 1'b0;
        steps(4);
        chk("idle_enb", vco_enb, 1);

        // Static low, then one 0->1 step inside a window, then static high
        tog = 1'b0;
        p_lvl = 1'b0;
        steps(8);
        exp_q.push_back(16'd0);
        base = pops;
        en = 1'b1;
        t = 0;
        wait_pops(base + 1, 60);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd0);
        steps(4);
        p_lvl = 1'b1;
        wait_pops(base + 3, 60);
        en = 1'b0;
        steps(4);

        // Backpressure, overrun, clear, set-wins, same-cycle boundary
        sample_ready = 1'b0;
        tog = 1'b1;
        steps(8);
        en = 1'b1;
        t = 0;
        steps(21);
        chk("bp_valid1", sample_valid, 1);
        chk("bp_data1",  sample_data, 8);
        chk("bp_ovr0",   overrun, 0);
        tog = 1'b0;
        p_lvl = 1'b0;
        steps(16);
        chk("bp_ovr_set",  overrun, 1);
        chk("bp_valid2",   sample_valid, 1);
        chk("bp_data_hold", sample_data, 8);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("bp_ovr_clr", overrun, 0);
        steps(14);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        chk("bp_data_hold2", sample_data, 8);
        steps(7);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("bp_ovr_clr2", overrun, 0);
        exp_q.push_back(16'd8);
        exp_q.push_back(16'd0);
        base = pops;
        steps(7);
        sample_ready = 1'b1;
        step();
        chk("bnd_valid", sample_valid, 1);
        chk("bnd_ovr",   overrun, 0);
        en = 1'b0;
        wait_pops(base + 2, 10);
        steps(4);

        // Disable mid-window at w=7, then restart latency
        tog = 1'b1;
        steps(8);
        en = 1'b1;
        t = 0;
        steps(12);
        en = 1'b0;
        step();
        chk("dis_enb",   vco_enb, 1);
        chk("dis_busy",  busy, 0);
        chk("dis_valid", sample_valid, 0);
        steps(17);
        chk("no_partial", sample_valid, 0);
        exp_q.push_back(16'd8);
        base = pops;
        en = 1'b1;
        t = 0;
        wait_valid(100);
        chk("restart_t", t, 1 + SETTLE + OSR);
        en = 1'b0;
        wait_pops(base + 1, 10);
        steps(4);

        // Asynchronous reset mid-window with a sample pending
        sample_ready = 1'b0;
        en = 1'b1;
        t = 0;
        steps(31);
        chk("pre_rst_valid", sample_valid, 1);
        #3;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("arst_enb",   vco_enb, 1);
        chk("arst_data",  sample_data, 0);
        chk("arst_valid", sample_valid, 0);
        chk("arst_ovr",   overrun, 0);
        chk("arst_busy",  busy, 0);
        step();
        rst_n = 1'b1;
        steps(10);
        chk("post_rst_enb",   vco_enb, 1);
        chk("post_rst_busy",  busy, 0);
        chk("post_rst_valid", sample_valid, 0);

        chk("sb_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vco_edge_decoder.md
# vco_edge_decoder

Digital back-end for the VCO-based ADC. It enables the VCO, samples its single-bit phase output `p`, counts rising edges over a fixed decimation window of OSR clock cycles, and delivers each count as one ADC sample over a valid/ready interface to the downstream filter or Wishbone register bank. It is the receiving end of the VCO's `enb`/`p` pair and sits directly beside the `vco` instance in the user area.

## Interface
Parameters:
- `OSR`, 256: window length in `clk` cycles; must be at least 4.
- `SETTLE_CYC`, 4: cycles to wait after enabling the VCO before counting starts; must be at least 3 so the synchronizer flushes.
- `DATA_W`, 16: sample width. Must satisfy 2^DATA_W − 1 ≥ OSR/2.

Ports:
- `clk`, in, 1: system clock, same clock that drives `vco`.
- `rst_n`, in, 1: asynchronous active-low reset. Reset is asynchronous and active-low.
- `en`, in, 1: run request, level-sensitive.
- `p`, in, 1: VCO phase output, asynchronous to `clk`.
- `vco_enb`, out, 1: drives `vco.enb`, active-low. 0 means the VCO runs.
- `sample_data`, out, DATA_W: edge count of the last completed window.
- `sample_valid`, out, 1: `sample_data` holds an unconsumed sample.
- `sample_ready`, in, 1: consumer accepts the sample.
- `overrun`, out, 1: sticky flag, set when a sample has been dropped.
- `clr_ovr`, in, 1: single-cycle pulse that clears `overrun`.
- `busy`, out, 1: 1 in SETTLE or COUNT.

## Operation
- **Input path.** `p` passes through a 2-flop synchronizer (`s1`, `s2`) and then an edge-history flop (`s3`). A rising edge is counted in a cycle where `s2 & ~s3`.
- **States.**
  - IDLE: `vco_enb=1`, nothing counts.
  - IDLE→SETTLE when `en=1`.
  - SETTLE: `vco_enb=0`. A settle counter runs for SETTLE_CYC cycles, and edges are ignored.
  - SETTLE→COUNT after SETTLE_CYC cycles. The window counter `w` and the edge counter `e` both start at 0.
  - COUNT: `vco_enb=0`. `w` increments each cycle. `e` increments on each detected edge.
  - From any non-IDLE state, `en=0` returns the block to IDLE on the next edge. A partial window is discarded, and a pending valid sample is kept.
- **Window end.** In the cycle where `w==OSR-1`, the final count `e_final` includes any edge detected in that cycle. Next cycle:
  - `w=0`.
  - `e` = 1 if an edge is detected in that cycle, otherwise 0. There is no dead cycle between windows.
- **Delivery.** When a window ends:
  - If `sample_valid=0`, or `sample_ready=1` in the same cycle: load `sample_data=e_final` and set `sample_valid=1`.
  - Otherwise: drop `e_final`, keep the old sample, and set `overrun=1`.
- **Handshake.** A transfer happens on a clock edge where `sample_valid & sample_ready`. `sample_valid` clears unless a new sample loads in that same cycle. `sample_data` is stable while `sample_valid=1` and no transfer occurs.
- **Overrun flag.** `overrun` is cleared by `clr_ovr`. If a set and a clear happen in the same cycle, the set wins.
- **Count width.** The edge counter saturates at 2^DATA_W − 1. Saturation cannot occur when the parameter rule is met; it is a guard only.

## Timing
- **Reset values.** `vco_enb=1`, `sample_data=0`, `sample_valid=0`, `overrun=0`, `busy=0`, state IDLE, all counters and synchronizer flops 0.
- **Output register.** All outputs come straight from flops; there is no combinational path from inputs to outputs.
- **Start-up.** `en` rises at edge 0:
  - `vco_enb` falls and `busy` rises after edge 1.
  - COUNT starts after edge 1+SETTLE_CYC.
  - The first `sample_valid` rises OSR cycles later.
- **Latency.** Three cycles from `p` to the edge counter. The sample appears one cycle after `w==OSR-1`.
- **Mid-operation reset.** `rst_n` asserted at any time forces the reset values immediately, with no edge required.

## Structure
- A shared package `vco_adc_pkg` holds:
  - the state enum (IDLE, SETTLE, COUNT);
  - defaults for OSR, SETTLE_CYC and DATA_W;
  - the `$clog2` width helper for the window and settle counters.
- One sub-module, `sync_edge_det`: the 2-flop synchronizer plus history flop, with outputs `p_sync` and `rise`. It is reused by later decoder channels.
- The FSM, the counters and the output holding register stay in the top module.

## Test plan
- **Toggling input.** OSR=16. `p` toggles every `clk` (one rising edge per two cycles) → each sample = 8, with `sample_ready` held 1.
- **Static input.** `p` held at 0 or 1 → every sample = 0. A single 0→1 step inside one window → that sample = 1, then 0.
- **Backpressure.**
  - `sample_ready=0` for two windows → the first sample is held unchanged, the second is dropped and `overrun=1`.
  - A `clr_ovr` pulse clears the flag.
  - `clr_ovr` in the same cycle as a new overrun → `overrun` stays 1.
- **Same-cycle boundary.** A transfer in the exact cycle the next window ends → the new sample loads, `sample_valid` stays 1 and `overrun` stays 0.
- **Disable mid-window.** `en=0` at `w=7` → IDLE next cycle, `vco_enb=1`, no sample emitted. Re-enabling gives SETTLE_CYC+OSR cycles before the next `sample_valid`.
- **Reset mid-window.** `rst_n` low with `sample_valid=1` and `w=10` → all outputs take their reset values asynchronously. After release the block stays IDLE until `en` is asserted.
